zero_scan_ctrl: RTL and testbench

//  Sequencer that time-shares one zero_check #(.N(C)) instance across a wide W-bit operand.
//  - Scans the operand one C-bit chunk per cycle, lowest chunk first.
//  - Reports zero/nzero and the index of the lowest nonzero chunk.
//  - Sits beside the ALU/branch datapath, where wide compare results need zero detection

---
 rtl/zero_scan_ctrl.sv | 154 +++++++++++++++
 tb/tb_zero_scan_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/zero_scan_ctrl.sv
// Zero detector for a wide operand that reuses one C-bit zero_check, scanning one chunk per cycle.
// Optional macro ZERO_SCAN_EARLY_EXIT_EN stops the scan at the first nonzero chunk.

module zero_check #(
    parameter int N = 32
) (
    input  logic [N-1:0] a,
    output logic         zero,
    output logic         nzero
);
    assign nzero = |a;
    assign zero  = ~nzero;
endmodule

module zero_scan_ctrl #(
    parameter  int W   = 128,
    parameter  int C   = 32,
    localparam int NCH = W / C,
    localparam int IW  = $clog2(NCH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_zero,
    output logic          out_nzero,
    output logic [IW-1:0] out_idx,
    output logic          busy
);

    generate
        if ((W % C) != 0 || NCH < 2) begin : g_bad_params
            $fatal(1, "zero_scan_ctrl: W must be a multiple of C with at least two chunks");
        end
    endgenerate

`ifdef ZERO_SCAN_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    localparam logic [IW-1:0] LAST = IW'(NCH - 1);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t        state, next_state;
    logic [W-1:0]  data_reg;
    logic [IW-1:0] cnt;
    logic [IW-1:0] idx;
    logic          found;
    logic          result_zero;
    logic [C-1:0]  chunks [NCH];
    logic [C-1:0]  chunk;
    logic          chk_zero;
    logic          chk_nzero;
    logic          terminate;

    always_comb begin
        for (int k = 0; k < NCH; k++) begin
            chunks[k] = data_reg[k*C +: C];
        end
    end

    assign chunk = chunks[cnt];

    zero_check #(.N(C)) u_chk (
        .a     (chunk),
        .zero  (chk_zero),
        .nzero (chk_nzero)
    );

    assign terminate = (cnt == LAST) || (EARLY && chk_nzero);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Outputs fall back to the idle values (zero reported, index 0) outside DONE
    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        out_zero   = 1'b1;
        out_nzero  = 1'b0;
        out_idx    = '0;
        busy       = (state != IDLE);
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    next_state = SCAN;
                end
            end
            SCAN: begin
                if (terminate) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                out_zero  = result_zero;
                out_nzero = ~result_zero;
                out_idx   = idx;
                if (out_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // idx keeps only the first nonzero chunk, so it stays 0 for an all-zero operand
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_reg    <= '0;
            cnt         <= '0;
            idx         <= '0;
            found       <= 1'b0;
            result_zero <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        data_reg <= in_data;
                        cnt      <= '0;
                        idx      <= '0;
                        found    <= 1'b0;
                    end
                end
                SCAN: begin
                    if (chk_nzero && !found) begin
                        found <= 1'b1;
                        idx   <= cnt;
                    end
                    if (terminate) begin
                        result_zero <= ~found & chk_zero;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_zero_scan_ctrl.sv
// Directed and randomized checks of zero_scan_ctrl against a chunk-level reference model.
// Honours ZERO_SCAN_EARLY_EXIT_EN for the expected latency.

module tb_zero_scan_ctrl;

    localparam int W   = 128;
    localparam int C   = 32;
    localparam int NCH = W / C;

`ifdef ZERO_SCAN_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_data = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic         out_zero;
    logic         out_nzero;
    logic [1:0]   out_idx;
    logic         busy;

    int n_checks = 0;
    int n_fail   = 0;

    zero_scan_ctrl #(.W(W), .C(C)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_zero  (out_zero),
        .out_nzero (out_nzero),
        .out_idx   (out_idx),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Lowest chunk holding any set bit, found by plain shifting and masking
    function automatic int ref_idx(input logic [W-1:0] d);
        logic [W-1:0] mask;
        mask = (W'(1) << C) - W'(1);
        for (int k = 0; k < NCH; k++) begin
            if (((d >> (k * C)) & mask) != '0) return k;
        end
        return 0;
    endfunction

    function automatic int ref_latency(input logic [W-1:0] d);
        if (d == '0 || !EARLY) return NCH + 1;
        return ref_idx(d) + 2;
    endfunction

    task automatic applyStimulus(input logic [W-1:0] d, input bit keep_valid);
        checkOutput("in_ready_before_accept", 32'(in_ready), 32'd1);
        in_data  = d;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        if (!keep_valid) in_valid = 1'b0;
        checkOutput("busy_after_accept", 32'(busy), 32'd1);
    endtask

    task automatic waitResult(input string tag, input logic [W-1:0] d);
        int k;
        k = 0;
        while (!out_valid && k < 20) begin
            @(posedge clk);
            #1;
            k++;
        end
        checkOutput({tag, "_latency"}, 32'(k + 1), 32'(ref_latency(d)));
        checkOutput({tag, "_zero"}, 32'(out_zero), 32'(d == '0));
        checkOutput({tag, "_nzero"}, 32'(out_nzero), 32'(d != '0));
        checkOutput({tag, "_idx"}, 32'(out_idx), 32'(ref_idx(d)));
        checkOutput({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    endtask

    task automatic handshake(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checkOutput({tag, "_hs_valid"}, 32'(out_valid), 32'd0);
        checkOutput({tag, "_hs_ready"}, 32'(in_ready), 32'd1);
        checkOutput({tag, "_hs_busy"}, 32'(busy), 32'd0);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        checkOutput({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        checkOutput({tag, "_out_zero"}, 32'(out_zero), 32'd1);
        checkOutput({tag, "_out_nzero"}, 32'(out_nzero), 32'd0);
        checkOutput({tag, "_out_idx"}, 32'(out_idx), 32'd0);
        checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        logic [W-1:0] d;
        logic [W-1:0] a;
        logic [W-1:0] b;
        int           valid_seen;

        $display("[TB] zero_scan_ctrl bench, early exit = %0d", EARLY);

        #2;
        checkResetValues("por");
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset while scanning must drop the operand without ever raising out_valid
        applyStimulus({1'b1, 127'b0}, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        checkResetValues("rst_scan");
        @(posedge clk);
        #1;
        reset = 1'b0;
        valid_seen = 0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (out_valid) valid_seen++;
        end
        checkOutput("rst_scan_no_valid", 32'(valid_seen), 32'd0);

        applyStimulus('0, 1'b0);
        waitResult("t1_zero", '0);
        handshake("t1");

        applyStimulus(W'(1), 1'b0);
        waitResult("t2_bit0", W'(1));
        handshake("t2");

        d = {1'b1, 127'b0};
        applyStimulus(d, 1'b0);
        waitResult("t3_bit127", d);
        handshake("t3a");

        d = (W'(1) << 40) | (W'(1) << 100);
        applyStimulus(d, 1'b0);
        waitResult("t3_two_bits", d);
        reset = 1'b1;
        #1;
        checkResetValues("rst_done");
        @(posedge clk);
        #1;
        reset = 1'b0;

        // DONE must hold its result while the consumer stalls
        d = W'(1) << 70;
        applyStimulus(d, 1'b0);
        waitResult("t4_stall", d);
        repeat (10) begin
            in_data  = {$urandom, $urandom, $urandom, $urandom};
            @(posedge clk);
            #1;
            checkOutput("t4_hold_valid", 32'(out_valid), 32'd1);
            checkOutput("t4_hold_idx", 32'(out_idx), 32'd2);
            checkOutput("t4_hold_nzero", 32'(out_nzero), 32'd1);
            checkOutput("t4_hold_in_ready", 32'(in_ready), 32'd0);
        end
        handshake("t4");

        a = W'(1) << 33;
        b = W'(1) << 5;
        applyStimulus(a, 1'b1);
        in_data = b;
        waitResult("t5_first", a);
        handshake("t5a");
        applyStimulus(b, 1'b0);
        waitResult("t5_second", b);
        handshake("t5b");

        for (int i = 0; i < W; i++) begin
            d    = '0;
            d[i] = 1'b1;
            applyStimulus(d, 1'b0);
            waitResult($sformatf("t6_bit%0d", i), d);
            handshake("t6");
        end
        applyStimulus('0, 1'b0);
        waitResult("t6_zero", '0);
        handshake("t6z");

        // Random operands with whole chunks randomly cleared so every index shows up
        repeat (12) begin
            d = {$urandom, $urandom, $urandom, $urandom};
            for (int k = 0; k < NCH; k++) begin
                if ($urandom_range(0, 1) == 0) d[k*C +: C] = '0;
            end
            applyStimulus(d, 1'b0);
            waitResult("t6_rand", d);
            handshake("t6r");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
